// File: rtl/pipe_stall_ctrl_if.sv
// Pipeline control bus between the stage logic and pipe_stall_ctrl.
// master: pipeline side (drives requests, consumes stall/flush).
// slave:  controller side.
interface pipe_stall_ctrl_if #(
    parameter int unsigned CNT_W = 32
);
    logic             stallreq_id;
    logic             stallreq_mem;
    logic             mc_req;
    logic             mc_done;
    logic             br_taken;
    logic [31:0]      br_target;
    logic [5:0]       stall;
    logic             mc_start;
    logic             flush;
    logic [31:0]      new_pc;
    logic [CNT_W-1:0] stall_cnt;
    logic             mem_timeout;

    modport master (
        output stallreq_id, stallreq_mem, mc_req, mc_done, br_taken, br_target,
        input  stall, mc_start, flush, new_pc, stall_cnt, mem_timeout
    );

    modport slave (
        input  stallreq_id, stallreq_mem, mc_req, mc_done, br_taken, br_target,
        output stall, mc_start, flush, new_pc, stall_cnt, mem_timeout
    );
endinterface

// File: rtl/pipe_stall_ctrl.sv
// Central stall/flush controller for the 6-stage pipeline (PC, IF, ID, EX, MEM, WB).
// Merges stall requests into one freeze vector, sequences the EX multi-cycle unit,
// generates branch flush, counts stalled cycles and watches for stuck memory waits.
module pipe_stall_ctrl #(
    parameter int unsigned CNT_W       = 32,
    parameter int unsigned TO_W        = 8,
    parameter int unsigned MEM_TIMEOUT = 200
) (
    input  logic             clk,
    input  logic             rst,
    pipe_stall_ctrl_if.slave bus
);

    typedef enum logic [1:0] {
        StRun    = 2'd0,
        StMcWait = 2'd1,
        StMcDone = 2'd2
    } state_e;

    localparam logic [TO_W-1:0]  TO_MAX  = TO_W'(MEM_TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    localparam logic [5:0] MASK_MEM = 6'b011111;
    localparam logic [5:0] MASK_EX  = 6'b001111;
    localparam logic [5:0] MASK_ID  = 6'b000111;

    state_e           r_state;
    state_e           w_state_next;
    logic             w_ex_hold;
    logic             w_mc_start;
    logic [5:0]       w_stall;
    logic             w_flush;
    logic [CNT_W-1:0] r_stall_cnt;
    logic [TO_W-1:0]  r_wait_cnt;
    logic             r_mem_timeout;

    // Multi-cycle handshake: next state, EX hold and start pulse
    always_comb begin
        w_state_next = r_state;
        w_ex_hold    = 1'b0;
        w_mc_start   = 1'b0;
        unique case (r_state)
            StRun: begin
                // The unit is started even under a MEM stall
                if (bus.mc_req) begin
                    w_mc_start   = 1'b1;
                    w_ex_hold    = 1'b1;
                    w_state_next = StMcWait;
                end
            end
            StMcWait: begin
                if (!bus.mc_done) begin
                    w_ex_hold = 1'b1;
                end else if (bus.stallreq_mem) begin
                    // Result is latched by the unit; EX just waits behind MEM
                    w_state_next = StMcDone;
                end else begin
                    w_state_next = StRun;
                end
            end
            StMcDone: begin
                if (!bus.stallreq_mem) begin
                    w_state_next = StRun;
                end
            end
            default: w_state_next = StRun;
        endcase
    end

    // Stall vector, flush and output gating (all outputs read 0 during reset)
    always_comb begin
        w_stall = 6'b000000;
        if (bus.stallreq_mem) w_stall = w_stall | MASK_MEM;
        if (w_ex_hold)        w_stall = w_stall | MASK_EX;
        if (bus.stallreq_id)  w_stall = w_stall | MASK_ID;
        if (rst)              w_stall = 6'b000000;

        // A branch sitting in a frozen EX must not redirect yet
        w_flush = bus.br_taken & ~w_stall[3] & ~rst;

        bus.stall       = w_stall;
        bus.mc_start    = w_mc_start & ~rst;
        bus.flush       = w_flush;
        bus.new_pc      = w_flush ? bus.br_target : 32'h0;
        bus.stall_cnt   = rst ? '0 : r_stall_cnt;
        bus.mem_timeout = r_mem_timeout & ~rst;
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= StRun;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Saturating count of cycles with the PC stage frozen
    always_ff @(posedge clk) begin
        if (rst) begin
            r_stall_cnt <= '0;
        end else if (w_stall[0] && (r_stall_cnt != CNT_MAX)) begin
            r_stall_cnt <= r_stall_cnt + 1'b1;
        end
    end

    // Memory-wait watchdog: consecutive request cycles, sticky flag on reaching the limit
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wait_cnt    <= '0;
            r_mem_timeout <= 1'b0;
        end else if (bus.stallreq_mem) begin
            if (r_wait_cnt != TO_MAX) begin
                r_wait_cnt <= r_wait_cnt + 1'b1;
            end
            if (r_wait_cnt >= TO_MAX - 1'b1) begin
                r_mem_timeout <= 1'b1;
            end
        end else begin
            r_wait_cnt <= '0;
        end
    end

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Scoreboard bench for pipe_stall_ctrl: directed scenarios then random traffic.
// A second instance with a 4-bit stall counter shares the inputs to show saturation.
module tb_pipe_stall_ctrl;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    pipe_stall_ctrl_if #(.CNT_W(32)) bus ();
    pipe_stall_ctrl_if #(.CNT_W(4))  bus4 ();

    assign bus4.stallreq_id  = bus.stallreq_id;
    assign bus4.stallreq_mem = bus.stallreq_mem;
    assign bus4.mc_req       = bus.mc_req;
    assign bus4.mc_done      = bus.mc_done;
    assign bus4.br_taken     = bus.br_taken;
    assign bus4.br_target    = bus.br_target;

    pipe_stall_ctrl #(.CNT_W(32), .TO_W(8), .MEM_TIMEOUT(200)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    pipe_stall_ctrl #(.CNT_W(4), .TO_W(8), .MEM_TIMEOUT(200)) dut4 (
        .clk (clk),
        .rst (rst),
        .bus (bus4)
    );

    typedef struct packed {
        logic [5:0]  stall;
        logic        mc_start;
        logic        flush;
        logic [31:0] new_pc;
        logic [31:0] cnt;
        logic [3:0]  cnt4;
        logic        to;
    } exp_t;

    exp_t q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    // Reference model state: what the multi-cycle unit is doing, plus counters
    bit     m_unit_busy;
    bit     m_result_parked;
    bit     m_to;
    longint m_cnt;
    int     m_cnt4;
    int     m_wait;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp_v);
        n_checks++;
        if (act !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp_v, $time);
        end
    endtask

    // One clock cycle of stimulus; expected outputs for this cycle go to the scoreboard
    task automatic cyc(input bit r, input bit id, input bit mem, input bit req,
                       input bit done, input bit br, input logic [31:0] tgt);
        exp_t e;
        bit   hold;
        bit   start;
        int   depth;
        @(posedge clk);
        #1;
        rst              = r;
        bus.stallreq_id  = id;
        bus.stallreq_mem = mem;
        bus.mc_req       = req;
        bus.mc_done      = done;
        bus.br_taken     = br;
        bus.br_target    = tgt;
        e = '0;
        if (r) begin
            m_unit_busy = 0; m_result_parked = 0; m_to = 0;
            m_cnt = 0; m_cnt4 = 0; m_wait = 0;
            q.push_back(e);
            return;
        end
        hold  = 0;
        start = 0;
        if (m_unit_busy) begin
            if (!done) hold = 1;
            else begin
                m_unit_busy     = 0;
                m_result_parked = mem;
            end
        end else if (m_result_parked) begin
            if (!mem) m_result_parked = 0;
        end else if (req) begin
            start       = 1;
            hold        = 1;
            m_unit_busy = 1;
        end
        // Deepest stage requesting a freeze; everything upstream of it freezes too
        depth = mem ? 4 : hold ? 3 : id ? 2 : -1;
        e.stall    = (depth < 0) ? 6'd0 : 6'((1 << (depth + 1)) - 1);
        e.mc_start = start;
        e.flush    = br && (depth < 3);
        e.new_pc   = e.flush ? tgt : 32'h0;
        e.cnt      = 32'(m_cnt);
        e.cnt4     = 4'(m_cnt4);
        e.to       = m_to;
        q.push_back(e);
        if (e.stall[0]) begin
            if (m_cnt < 64'hFFFF_FFFF) m_cnt++;
            if (m_cnt4 < 15) m_cnt4++;
        end
        m_wait = mem ? ((m_wait < 200) ? m_wait + 1 : 200) : 0;
        if (m_wait == 200) m_to = 1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0, 0, 32'h0);
    endtask

    // Monitor: compare every DUT output against the oldest expectation
    exp_t m_e;
    always @(negedge clk) begin
        if (q.size() > 0) begin
            m_e = q.pop_front();
            chk("stall",       64'(bus.stall),        64'(m_e.stall));
            chk("mc_start",    64'(bus.mc_start),     64'(m_e.mc_start));
            chk("flush",       64'(bus.flush),        64'(m_e.flush));
            chk("new_pc",      64'(bus.new_pc),       64'(m_e.new_pc));
            chk("stall_cnt",   64'(bus.stall_cnt),    64'(m_e.cnt));
            chk("stall_cnt4",  64'(bus4.stall_cnt),   64'(m_e.cnt4));
            chk("mem_timeout", 64'(bus.mem_timeout),  64'(m_e.to));
        end
    end

    initial begin
        int guard;
        bit r, id, mem, req, done, br;
        rst = 1'b1;
        bus.stallreq_id = 0; bus.stallreq_mem = 0; bus.mc_req = 0;
        bus.mc_done = 0; bus.br_taken = 0; bus.br_target = 32'h0;

        cyc(1, 0, 0, 0, 0, 0, 32'h0);
        cyc(1, 0, 0, 0, 0, 0, 32'h0);
        idle(2);

        // Mask priority
        for (int i = 0; i < 3; i++) cyc(0, 1, 0, 0, 0, 0, 32'h0);
        for (int i = 0; i < 2; i++) cyc(0, 1, 1, 0, 0, 0, 32'h0);
        idle(1);

        // Multi-cycle handshake, done 5 cycles after start
        for (int i = 0; i < 5; i++) cyc(0, 0, 0, 1, 0, 0, 32'h0);
        cyc(0, 0, 0, 1, 1, 0, 32'h0);
        idle(3);

        // Done under MEM stall, mc_req kept high while parked
        for (int i = 0; i < 3; i++) cyc(0, 0, 0, 1, 0, 0, 32'h0);
        cyc(0, 0, 1, 1, 1, 0, 32'h0);
        for (int i = 0; i < 2; i++) cyc(0, 0, 1, 1, 0, 0, 32'h0);
        cyc(0, 0, 0, 0, 0, 0, 32'h0);
        idle(2);

        // Branch: free, held behind MEM, and together with an ID stall
        cyc(0, 0, 0, 0, 0, 1, 32'h8000_0040);
        for (int i = 0; i < 3; i++) cyc(0, 0, 1, 0, 0, 1, 32'h8000_0040);
        cyc(0, 0, 0, 0, 0, 1, 32'h8000_0040);
        cyc(0, 1, 0, 0, 0, 1, 32'h1234_5678);
        idle(1);

        // Stall counter: 10 then 20 total (4-bit copy saturates at 15)
        cyc(1, 0, 0, 0, 0, 0, 32'h0);
        for (int i = 0; i < 10; i++) cyc(0, 1, 0, 0, 0, 0, 32'h0);
        idle(1);
        for (int i = 0; i < 10; i++) cyc(0, 1, 0, 0, 0, 0, 32'h0);
        idle(1);

        // Watchdog: 199 cycles not enough, 200 trips, sticky until reset
        for (int i = 0; i < 199; i++) cyc(0, 0, 1, 0, 0, 0, 32'h0);
        idle(2);
        for (int i = 0; i < 200; i++) cyc(0, 0, 1, 0, 0, 0, 32'h0);
        idle(2);
        cyc(1, 0, 0, 0, 0, 0, 32'h0);
        idle(1);

        // Reset in the middle of a multi-cycle wait
        for (int i = 0; i < 3; i++) cyc(0, 0, 0, 1, 0, 0, 32'h0);
        cyc(1, 0, 0, 1, 0, 0, 32'h0);
        cyc(0, 0, 0, 1, 0, 0, 32'h0);
        cyc(0, 0, 0, 1, 1, 0, 32'h0);
        idle(1);

        // Random traffic
        for (int i = 0; i < 600; i++) begin
            r    = ($urandom_range(63) == 0);
            id   = ($urandom_range(3) == 0);
            mem  = ($urandom_range(3) == 0);
            req  = ($urandom_range(2) == 0);
            done = ($urandom_range(3) == 0);
            br   = ($urandom_range(2) == 0);
            cyc(r, id, mem, req, done, br, $urandom);
        end
        idle(1);

        guard = 0;
        while (q.size() > 0 && guard < 10) begin
            @(posedge clk);
            guard++;
        end
        if (q.size() > 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL drain: %0d expectations left, required 0", q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/pipe_stall_ctrl.md
Name: pipe_stall_ctrl

Overview:
- Central pipeline controller for the 6-stage core (PC, IF, ID, EX, MEM, WB; stage index 0..5).
- Collects stall requests from ID (load-use), MEM (data bus wait) and the EX multi-cycle unit, and drives the shared `stall[5:0]` vector consumed by every stage register, including WB.
- Sequences the EX multi-cycle unit through a start/done handshake.
- Generates branch flush, and keeps a stall-cycle counter and a memory-wait watchdog.

Parameters:
- `CNT_W`, 32, width of the saturating stall-cycle counter.
- `TO_W`, 8, width of the memory-wait watchdog counter.
- `MEM_TIMEOUT`, 200, consecutive `stallreq_mem` cycles that trip the watchdog (must fit in `TO_W`, must be ≥1).

Ports:
- `clk`  in  1  the single clock; all state updates on posedge.
- `rst`  in  1  synchronous reset, active-high.
- `stallreq_id`  in  1  ID load-use hazard request.
- `stallreq_mem`  in  1  MEM data bus not ready.
- `mc_req`  in  1  EX holds a multi-cycle instruction (mul/div).
- `mc_done`  in  1  one-cycle pulse: multi-cycle result valid.
- `br_taken`  in  1  EX resolved a taken branch/jump.
- `br_target`  in  32  branch target address.
- `stall`  out  6  `stall[k]=1` freezes stage k register; `stall[k-1]&!stall[k]` bubbles stage k.
- `mc_start`  out  1  one-cycle start pulse to the multi-cycle unit.
- `flush`  out  1  kill IF and ID contents this cycle.
- `new_pc`  out  32  redirect address, valid when `flush=1`.
- `stall_cnt`  out  `CNT_W`  saturating count of cycles with `stall[0]=1`.
- `mem_timeout`  out  1  sticky watchdog flag.

Behaviour:
- **Stall masks** (all combinational, same cycle):
  - `stallreq_mem` → `011111`
  - EX multi-cycle hold → `001111`
  - `stallreq_id` → `000111`
  - `stall` is the bitwise OR of active masks, so the highest requesting stage wins.
  - `stall[5]` is always 0.
- **Reset:** while `rst=1`, all outputs are 0 (`stall`, `mc_start`, `flush`, `new_pc` forced 0 combinationally).
  - Registers clear: state=RUN, `stall_cnt=0`, `wait_cnt=0`, `mem_timeout=0`.
  - Reset mid-operation abandons any handshake. No `mc_start` is reissued until `mc_req` is seen again in RUN.
- **FSM states** {RUN, MC_WAIT, MC_DONE}. "EX hold" means the EX mask is active.
  - **RUN:**
    - If `mc_req=1`: `mc_start=1` for this cycle only, EX hold active, next=MC_WAIT. This happens even when `stallreq_mem=1`; the unit starts regardless.
    - Otherwise no EX hold.
  - **MC_WAIT:**
    - If `mc_done=0`: EX hold active, stay.
    - If `mc_done=1` and `stallreq_mem=0`: no EX hold (EX advances this cycle), next=RUN.
    - If `mc_done=1` and `stallreq_mem=1`: no EX hold, next=MC_DONE.
  - **MC_DONE:**
    - No EX hold. `mc_start=0` even if `mc_req=1`, because the result is already latched by the unit.
    - Next=RUN when `stallreq_mem=0`, else stay.
  - `mc_start` is asserted only in RUN. `mc_done` outside MC_WAIT is ignored.
- **Flush:** `flush = br_taken & !stall[3] & !rst`; `new_pc = flush ? br_target : 0`.
  - A branch held in a stalled EX is not taken until EX advances.
  - Flush and an ID stall in the same cycle: both asserted. Flush kills ID; the stall vector is unchanged.
- **Stall counter:** `stall_cnt` increments at each posedge where `stall[0]=1`. It holds at all-ones (no wrap).
- **Watchdog:**
  - `wait_cnt` increments when `stallreq_mem=1`, saturating at `MEM_TIMEOUT`, and clears when `stallreq_mem=0`.
  - `mem_timeout` sets at the edge where `wait_cnt` reaches `MEM_TIMEOUT`, i.e. it reads 1 after `MEM_TIMEOUT` consecutive request cycles.
  - It stays set until `rst`. The flag is informational only and does not alter `stall`.

Test Plan:
- **Mask priority:** `stallreq_id=1` alone → `stall=000111`. Add `stallreq_mem=1` → `011111`. Release both → `000000` in the same cycle.
- **Multi-cycle handshake:** `mc_req=1` in RUN.
  - Required: `mc_start=1` exactly one cycle; `stall=001111` for that cycle plus every MC_WAIT cycle.
  - `mc_done` pulses 5 cycles after start → `stall=000000` on the done cycle. State returns to RUN with no second `mc_start` while `mc_req` drops.
- **Done under MEM stall:** `mc_done=1` with `stallreq_mem=1` → state MC_DONE, `stall=011111`, `mc_start` stays 0 with `mc_req` still high. Drop `stallreq_mem` → `stall=000000`, RUN next cycle.
- **Branch:**
  - `br_taken=1`, `br_target=0x8000_0040`, no stall → `flush=1`, `new_pc=0x8000_0040`.
  - Same with `stallreq_mem=1` → `flush=0` until the request drops.
- **Counters:**
  - 10 stall cycles → `stall_cnt=10`.
  - With `CNT_W=4`, 20 stall cycles → `stall_cnt=15`.
  - `stallreq_mem` held 199 cycles then low → `mem_timeout=0`. Held 200 cycles → `mem_timeout=1`, still 1 after release. `rst` → 0.
- **Reset mid-wait:** `rst` for 1 cycle during MC_WAIT → all outputs 0 during reset. Afterwards state is RUN, `stall_cnt=0`, and the next `mc_req` produces a fresh `mc_start`.
